ieee_754_divider: RTL and testbench

- Iterative IEEE 754 single-precision divider: result = rs1 / rs2.
- Companion to the ALU floating-point multiplier, with the same start/valid/busy handshake so the ALU sequencer drives both blocks identically.
- Uses restoring division, one quotient bit per cycle, with round-to-nearest-even.
- Denormal inputs and outputs are flushed to zero.

---
 rtl/ieee_754_divider.sv | 181 ++++++++++++++++++
 tb/tb_ieee_754_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_754_divider.sv
// Iterative IEEE 754 single-precision divider: restoring division,
// one quotient bit per cycle, round-to-nearest-even, denormals flushed.
module ieee_754_divider #(
  parameter int MANT_W = 24,
  parameter int QBITS  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        start,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    ROUND
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              za, zb, ia, ib, na, nb;
  logic              s_in;
  logic              spec_hit;
  logic [31:0]       spec_res;
  logic [MANT_W-1:0] ma_in, mb_in;
  logic              lt;
  logic [9:0]        e_in;
  logic [QBITS-1:0]  dividend;

  logic              sign;
  logic              special;
  logic [31:0]       spec_q;
  logic [9:0]        e_q;
  logic [MANT_W-1:0] mb;
  logic [QBITS-1:0]  rem;
  logic [QBITS-2:0]  q_r;
  logic [4:0]        cnt;

  logic [QBITS-1:0]  mb_ext;
  logic              ge;
  logic [QBITS-1:0]  rem_nxt;
  logic [QBITS-2:0]  q_nxt;

  logic              inc;
  logic [32:0]       wide;
  logic signed [9:0] e_r;
  logic [31:0]       rnd_res;

  assign ea   = rs1[30:23];
  assign eb   = rs2[30:23];
  assign fa   = rs1[22:0];
  assign fb   = rs2[22:0];
  assign s_in = rs1[31] ^ rs2[31];
  assign za   = (ea == 8'd0);
  assign zb   = (eb == 8'd0);
  assign ia   = (ea == 8'hFF) && (fa == 23'd0);
  assign ib   = (eb == 8'hFF) && (fb == 23'd0);
  assign na   = (ea == 8'hFF) && (fa != 23'd0);
  assign nb   = (eb == 8'hFF) && (fb != 23'd0);

  always_comb begin
    spec_hit = 1'b1;
    spec_res = 32'h7FC0_0000;
    if (na || nb || (za && zb) || (ia && ib)) begin
      spec_res = 32'h7FC0_0000;
    end else if (zb || ia) begin
      spec_res = {s_in, 8'hFF, 23'd0};
    end else if (za || ib) begin
      spec_res = {s_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
      spec_res = 32'd0;
    end
  end

  assign ma_in = {1'b1, fa};
  assign mb_in = {1'b1, fb};
  assign lt    = (ma_in < mb_in);
  assign e_in  = {2'b00, ea} - {2'b00, eb}
               + 10'd127 - {9'd0, lt};

  // Pre-normalise so the first quotient bit is always 1
  assign dividend = lt ? {1'b0, ma_in, 1'b0}
                       : {2'b00, ma_in};

  assign mb_ext  = {{(QBITS-MANT_W){1'b0}}, mb};
  assign ge      = (rem >= mb_ext);
  assign rem_nxt = (ge ? rem - mb_ext : rem) << 1;
  assign q_nxt   = {q_r[QBITS-3:0], ge};

  // The known-one quotient MSB is not stored; q_r holds q[24:0]
  assign inc  = q_r[1] & (q_r[0] | (rem != '0) | q_r[2]);
  assign wide = {e_q, q_r[24:2]} + {32'd0, inc};
  assign e_r  = wide[32:23];

  always_comb begin
    rnd_res = {sign, e_r[7:0], wide[22:0]};
    if (e_r >= 10'sd255) begin
      rnd_res = {sign, 8'hFF, 23'd0};
    end else if (e_r <= 10'sd0) begin
      rnd_res = {sign, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = spec_hit ? ROUND : DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt == 5'(QBITS-1)) begin
          state_nxt = ROUND;
        end
      end
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      sign    <= 1'b0;
      special <= 1'b0;
      spec_q  <= '0;
      e_q     <= '0;
      mb      <= '0;
      rem     <= '0;
      q_r     <= '0;
      cnt     <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign    <= s_in;
            special <= spec_hit;
            spec_q  <= spec_res;
            e_q     <= e_in;
            mb      <= mb_in;
            rem     <= dividend;
            q_r     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        DIVIDE: begin
          rem <= rem_nxt;
          q_r <= q_nxt;
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          result <= special ? spec_q : rnd_res;
          valid  <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee_754_divider.sv
// Randomised bench for ieee_754_divider against an exact-arithmetic
// division model with textbook round-to-nearest-even.
module tb_ieee_754_divider;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        start;
  logic [31:0] result;
  logic        valid;
  logic        busy;

  int n_vec;
  int n_err;

  ieee_754_divider dut (
    .clk    (clk),
    .rst    (rst),
    .rs1    (rs1),
    .rs2    (rs2),
    .start  (start),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {special, result}
  function automatic logic [32:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    bit za, zb, ia, ib, na, nb, sticky, up;
    longint unsigned ma, mb, num, q, kept, low, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    if (na || nb || (za && zb) || (ia && ib))
      return {1'b1, 32'h7FC00000};
    if (zb || ia)
      return {1'b1, s, 8'hFF, 23'd0};
    if (za || ib)
      return {1'b1, s, 31'd0};
    ma = 64'd8388608 + 64'(fa);
    mb = 64'd8388608 + 64'(fb);
    num = ma << 40;
    q = num / mb;
    sticky = (num % mb) != 0;
    e = ea - eb + 127;
    if (q >= (64'd1 << 40)) begin
      sh = 17;
    end else begin
      sh = 16;
      e = e - 1;
    end
    kept = q >> sh;
    low  = q & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    up = (low > half) ||
         ((low == half) && (sticky || kept[0]));
    kept = kept + 64'(up);
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int k;
    logic [7:0] ex;
    logic [22:0] m;
    k = $urandom_range(0, 15);
    m = 23'($urandom);
    if (k == 0) begin
      ex = 8'd0;
    end else if (k == 1) begin
      ex = 8'hFF;
      if ($urandom_range(0, 1) == 1) m = 23'd0;
    end else begin
      ex = 8'($urandom_range(1, 254));
    end
    return {1'($urandom), ex, m};
  endfunction

  // Called between edges with the DUT idle; returns just after accept
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = busy;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b);
    logic [32:0] r;
    int lat;
    bit bok;
    r = ref_div(a, b);
    start_op(a, b);
    wait_valid(lat, bok);
    check({tag, "_res"}, result, r[31:0]);
    check({tag, "_lat"}, 32'(lat), r[32] ? 32'd1 : 32'd27);
    check({tag, "_busy"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    int lat, nv;
    bit bok;
    logic [32:0] r;
    logic [31:0] a, b;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    rs1 = '0;
    rs2 = '0;
    #2;
    check("rst_result", result, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run("six_by_two", 32'h40C00000, 32'h40000000);
    check("six_by_two_k", result, 32'h40400000);
    run("third", 32'h3F800000, 32'h40400000);
    check("third_k", result, 32'h3EAAAAAB);
    run("neg_third", 32'hBF800000, 32'h40400000);
    check("neg_third_k", result, 32'hBEAAAAAB);
    run("one_by_zero", 32'h3F800000, 32'h00000000);
    check("one_by_zero_k", result, 32'h7F800000);
    run("neg_by_zero", 32'hBF800000, 32'h00000000);
    check("neg_by_zero_k", result, 32'hFF800000);
    run("zero_by_zero", 32'h00000000, 32'h00000000);
    check("zero_by_zero_k", result, 32'h7FC00000);
    run("inf_by_inf", 32'h7F800000, 32'h7F800000);
    check("inf_by_inf_k", result, 32'h7FC00000);
    run("overflow", 32'h7F000000, 32'h3E800000);
    check("overflow_k", result, 32'h7F800000);
    run("underflow", 32'h00800000, 32'h40000000);
    check("underflow_k", result, 32'h00000000);

    // Second start mid-DIVIDE must be ignored
    start_op(32'h40C00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #1;
    rs1 = 32'h3F800000;
    rs2 = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(lat, bok);
    check("ignore_res", result, 32'h40400000);
    check("ignore_lat", 32'(lat), 32'd21);

    // Start held high in the valid cycle
    start_op(32'h3F800000, 32'h40400000);
    wait_valid(lat, bok);
    check("b2b_first", result, 32'h3EAAAAAB);
    start_op(32'h40C00000, 32'h40000000);
    check("b2b_valid_drop", {31'd0, valid}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid(lat, bok);
    check("b2b_second", result, 32'h40400000);
    check("b2b_lat", 32'(lat), 32'd27);

    // Async reset at iteration 10
    start_op(32'h3F800000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
    check("arst_no_valid", 32'(nv), 32'd0);
    run("post_rst", 32'h40C00000, 32'h40000000);
    check("post_rst_k", result, 32'h40400000);

    for (int i = 0; i < 150; i++) begin
      a = rand_fp();
      b = rand_fp();
      if ($urandom_range(0, 3) == 0) b[30:23] = a[30:23];
      r = ref_div(a, b);
      run($sformatf("rnd%0d", i), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
